// File: rtl/seg_scan_display_if.sv
// -----------------------------------------------------------------------------
// seg_scan_display_if
//   Valid/ready input channel carrying one unsigned value to the display
//   controller.
//   Signals:
//     in_valid  master -> slave  in_data holds a value to display
//     in_data   master -> slave  unsigned value, DATA_W bits
//     in_ready  slave  -> master controller is idle and takes the value
//   Modports:
//     master  value producer (CPU output register side)
//     slave   display controller side
// -----------------------------------------------------------------------------
interface seg_scan_display_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//   Multi-digit 7-segment display controller. Takes a binary value over a
//   valid/ready channel, converts it to BCD one bit per clock (double dabble),
//   and scans DIGITS digits most-significant first. Each digit slot opens with
//   BLANK_CYCLES of all-off to stop ghosting. Leading zeros may be blanked, and
//   a value that does not fit in DIGITS decimal digits shows dashes and raises
//   o_overflow.
//   Ports:
//     i_clk       system clock
//     i_reset     synchronous, active-high reset
//     s_in        input channel (in_valid, in_data, in_ready), slave side
//     o_seg       segments {A,B,C,D,E,F,G}, bit6 = A, active-high
//     o_dig_en    digit enables, bit0 = ones digit, polarity per EN_ACTIVE_LOW
//     o_overflow  displayed value >= 10**DIGITS
// -----------------------------------------------------------------------------
module seg_scan_display #(
   parameter int DATA_W        = 8,
   parameter int DIGITS        = 3,
   parameter int SCAN_DIV      = 1024,
   parameter int BLANK_CYCLES  = 16,
   parameter int EN_ACTIVE_LOW = 1,
   parameter int LZ_SUPPRESS   = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   seg_scan_display_if.slave s_in,
   output logic [6:0]        o_seg,
   output logic [DIGITS-1:0] o_dig_en,
   output logic              o_overflow
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [BIT_W-1:0]  LP_BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  LP_CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  LP_BLANK     = CNT_W'(BLANK_CYCLES);
   localparam logic [SLOT_W-1:0] LP_SLOT_TOP  = SLOT_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] LP_EN_OFF    = (EN_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [6:0]        LP_SEG_DASH  = 7'b0000001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_COMMIT
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic               w_ready;

   logic [DATA_W-1:0]  r_shift;
   logic [BCD_W-1:0]   r_bcd;
   logic [BCD_W-1:0]   w_bcd_adj;
   logic               r_ovf_pend;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic [BCD_W-1:0]   r_disp_bcd;
   logic               r_overflow;

   logic [CNT_W-1:0]   r_scan_cnt;
   logic [SLOT_W-1:0]  r_slot;
   logic [DIGITS-1:0]  w_lead_zero;
   logic [DIGITS-1:0]  w_onehot;
   logic [3:0]         w_nib;
   logic               w_lz_blank;
   logic [6:0]         w_pattern;

   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    f_decode = 7'b1111110;
         4'd1:    f_decode = 7'b0110000;
         4'd2:    f_decode = 7'b1101101;
         4'd3:    f_decode = 7'b1111001;
         4'd4:    f_decode = 7'b0110011;
         4'd5:    f_decode = 7'b1011011;
         4'd6:    f_decode = 7'b1011111;
         4'd7:    f_decode = 7'b1110000;
         4'd8:    f_decode = 7'b1111111;
         4'd9:    f_decode = 7'b1110011;
         // Unreachable after a correct conversion; leave the digit dark.
         default: f_decode = 7'b0000000;
      endcase
   endfunction

   // ---------------------------------------------------------------- FSM --
   // NOTE: reset is synchronous, so it is tested inside the clocked branch
   // and is absent from the sensitivity list.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_ready      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (s_in.in_valid) w_next_state = S_CONV;
         end
         S_CONV: begin
            if (r_bit_cnt == LP_BIT_LAST) w_next_state = S_COMMIT;
         end
         S_COMMIT: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   assign s_in.in_ready = w_ready;

   // ------------------------------------------------------ double dabble --
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[i*4 +: 4] > 4'd4) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shift    <= '0;
         r_bcd      <= '0;
         r_ovf_pend <= 1'b0;
         r_bit_cnt  <= '0;
         r_disp_bcd <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (s_in.in_valid) begin
                  r_shift    <= s_in.in_data;
                  r_bcd      <= '0;
                  r_ovf_pend <= 1'b0;
                  r_bit_cnt  <= '0;
               end
            end
            S_CONV: begin
               r_shift    <= r_shift << 1;
               r_bcd      <= {w_bcd_adj[BCD_W-2:0], r_shift[DATA_W-1]};
               // The bit leaving the top belongs to a digit we cannot show.
               r_ovf_pend <= r_ovf_pend | w_bcd_adj[BCD_W-1];
               r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
            end
            S_COMMIT: begin
               r_disp_bcd <= r_bcd;
               r_overflow <= r_ovf_pend;
            end
            default: ;
         endcase
      end
   end

   assign o_overflow = r_overflow;

   // --------------------------------------------------------------- scan --
   // Free-running slot timer; the FSM never restarts it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_scan_cnt <= '0;
         r_slot     <= LP_SLOT_TOP;
      end else if (r_scan_cnt == LP_CNT_LAST) begin
         r_scan_cnt <= '0;
         r_slot     <= (r_slot == '0) ? LP_SLOT_TOP : r_slot - SLOT_W'(1);
      end else begin
         r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
   end

   // w_lead_zero[i]: digit i and everything above it are zero.
   always_comb begin
      w_lead_zero = '0;
      w_lead_zero[DIGITS-1] = (r_disp_bcd[BCD_W-1 -: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         w_lead_zero[i] = w_lead_zero[i+1] && (r_disp_bcd[i*4 +: 4] == 4'd0);
      end
   end

   assign w_nib      = r_disp_bcd[r_slot*4 +: 4];
   // Digit 0 is never suppressed so a zero value still shows "0".
   assign w_lz_blank = (LZ_SUPPRESS != 0) && (r_slot != '0) && w_lead_zero[r_slot];
   assign w_onehot   = DIGITS'(1) << r_slot;

   always_comb begin
      w_pattern = f_decode(w_nib);
      if (r_overflow)      w_pattern = LP_SEG_DASH;
      else if (w_lz_blank) w_pattern = 7'b0000000;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_seg    <= 7'b0000000;
         o_dig_en <= LP_EN_OFF;
      end else if (r_scan_cnt < LP_BLANK) begin
         o_seg    <= 7'b0000000;
         o_dig_en <= LP_EN_OFF;
      end else begin
         o_seg    <= w_pattern;
         o_dig_en <= LP_EN_OFF ^ w_onehot;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
//   Directed bench for seg_scan_display. Three instances share clock/reset:
//     u_a  DIGITS=3, leading-zero suppression on
//     u_b  DIGITS=3, leading-zero suppression off
//     u_c  DIGITS=2, suppression on (overflow cases)
//   All use DATA_W=8, SCAN_DIV=8, BLANK_CYCLES=2, active-low digit enables.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   seg_scan_display_if #(.DATA_W(8)) if_a ();
   seg_scan_display_if #(.DATA_W(8)) if_b ();
   seg_scan_display_if #(.DATA_W(8)) if_c ();

   logic [6:0] seg_a, seg_b, seg_c;
   logic [2:0] en_a, en_b;
   logic [1:0] en_c;
   logic       ovf_a, ovf_b, ovf_c;

   seg_scan_display #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(8), .BLANK_CYCLES(2),
                      .EN_ACTIVE_LOW(1), .LZ_SUPPRESS(1)) u_a (
      .i_clk(clk), .i_reset(reset), .s_in(if_a.slave),
      .o_seg(seg_a), .o_dig_en(en_a), .o_overflow(ovf_a));

   seg_scan_display #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(8), .BLANK_CYCLES(2),
                      .EN_ACTIVE_LOW(1), .LZ_SUPPRESS(0)) u_b (
      .i_clk(clk), .i_reset(reset), .s_in(if_b.slave),
      .o_seg(seg_b), .o_dig_en(en_b), .o_overflow(ovf_b));

   seg_scan_display #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(8), .BLANK_CYCLES(2),
                      .EN_ACTIVE_LOW(1), .LZ_SUPPRESS(1)) u_c (
      .i_clk(clk), .i_reset(reset), .s_in(if_c.slave),
      .o_seg(seg_c), .o_dig_en(en_c), .o_overflow(ovf_c));

   localparam logic [6:0] P0 = 7'b1111110, P2 = 7'b1101101, P3 = 7'b1111001,
                          P4 = 7'b0110011, P7 = 7'b1110000, DASH = 7'b0000001,
                          OFF = 7'b0000000;

   int n_cmp  = 0;
   int n_fail = 0;

   // Results of the last observe() call.
   logic [6:0] obs_seg [3];
   int         obs_act [3];
   int         obs_blank, obs_blank_err, obs_order_err, obs_bad;

   function automatic logic get_ready(input int sel);
      case (sel)
         0:       get_ready = if_a.in_ready;
         1:       get_ready = if_b.in_ready;
         default: get_ready = if_c.in_ready;
      endcase
   endfunction

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      case (sel)
         0:       begin if_a.in_valid = v; if_a.in_data = d; end
         1:       begin if_b.in_valid = v; if_b.in_data = d; end
         default: begin if_c.in_valid = v; if_c.in_data = d; end
      endcase
   endtask

   task automatic wait_ready(input int sel);
      int k;
      k = 0;
      while (!get_ready(sel) && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_ready[%0d]: in_ready not seen within 100 cycles", sel);
      end
   endtask

   // Sends one value; returns the number of cycles in_ready stayed low.
   task automatic send(input int sel, input logic [7:0] v, output int low);
      wait_ready(sel);
      @(negedge clk);
      drive(sel, 1'b1, v);
      @(posedge clk); #1;
      drive(sel, 1'b0, 8'h00);
      low = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (get_ready(sel)) break;
         low++;
      end
      // One extra edge so the registered outputs reflect the new value.
      @(posedge clk); #1;
   endtask

   // Watches one full scan rotation of the selected instance.
   task automatic observe(input int sel);
      int nd, d, n, prev;
      logic [6:0] s;
      logic [2:0] e;
      nd = (sel == 2) ? 2 : 3;
      prev = -1;
      for (int i = 0; i < 3; i++) begin obs_seg[i] = 'x; obs_act[i] = 0; end
      obs_blank = 0; obs_blank_err = 0; obs_order_err = 0; obs_bad = 0;
      for (int k = 0; k < nd * 8; k++) begin
         @(negedge clk);
         case (sel)
            0:       begin s = seg_a; e = en_a; end
            1:       begin s = seg_b; e = en_b; end
            default: begin s = seg_c; e = {1'b1, en_c}; end
         endcase
         if (e === 3'b111) begin
            obs_blank++;
            if (s !== OFF) obs_blank_err++;
         end else begin
            d = -1; n = 0;
            for (int i = 0; i < 3; i++) if (e[i] === 1'b0) begin d = i; n++; end
            if (n != 1) obs_bad++;
            else begin
               obs_seg[d] = s;
               obs_act[d]++;
               if (prev >= 0 && d != prev && d != ((prev == 0) ? nd - 1 : prev - 1))
                  obs_order_err++;
               prev = d;
            end
         end
      end
   endtask

   task automatic test_reset;
      drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00); drive(2, 1'b0, 8'h00);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if ({if_a.in_ready, if_b.in_ready, if_c.in_ready} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b want 111", {if_a.in_ready, if_b.in_ready, if_c.in_ready}); end
      n_cmp++; if ({seg_a, seg_b, seg_c} !== 21'd0) begin n_fail++; $display("FAIL reset_seg: got %h want 0", {seg_a, seg_b, seg_c}); end
      n_cmp++; if ({en_a, en_b, en_c} !== 8'hFF) begin n_fail++; $display("FAIL reset_en: got %b want 11111111", {en_a, en_b, en_c}); end
      n_cmp++; if ({ovf_a, ovf_b, ovf_c} !== 3'b000) begin n_fail++; $display("FAIL reset_ovf: got %b want 000", {ovf_a, ovf_b, ovf_c}); end
      n_cmp++; if (u_a.r_disp_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_disp: got %h want 000", u_a.r_disp_bcd); end
      reset = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (if_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", if_a.in_ready); end
   endtask

   task automatic test_zero;
      int low;
      send(0, 8'd0, low);
      n_cmp++; if (low !== 9) begin n_fail++; $display("FAIL zero_ready_low: got %0d want 9", low); end
      observe(0);
      n_cmp++; if (obs_seg[0] !== P0) begin n_fail++; $display("FAIL zero_slot0: got %b want %b", obs_seg[0], P0); end
      n_cmp++; if ({obs_seg[2], obs_seg[1]} !== {OFF, OFF}) begin n_fail++; $display("FAIL zero_slots21: got %b %b want 0 0", obs_seg[2], obs_seg[1]); end
   endtask

   task automatic test_value_233;
      wait_ready(0);
      @(negedge clk);
      drive(0, 1'b1, 8'd233);
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h00);
      repeat (8) @(posedge clk);
      #1;
      n_cmp++; if (u_a.r_disp_bcd !== 12'h000) begin n_fail++; $display("FAIL lat_early: got %h want 000", u_a.r_disp_bcd); end
      @(posedge clk); #1;
      n_cmp++; if (u_a.r_disp_bcd !== 12'h233) begin n_fail++; $display("FAIL lat_commit: got %h want 233", u_a.r_disp_bcd); end
      n_cmp++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_233: got %b want 0", ovf_a); end
      n_cmp++; if (if_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_233: got %b want 1", if_a.in_ready); end
      @(posedge clk); #1;
      observe(0);
      n_cmp++; if ({obs_seg[2], obs_seg[1], obs_seg[0]} !== {P2, P3, P3}) begin n_fail++; $display("FAIL show_233: got %b %b %b want %b %b %b", obs_seg[2], obs_seg[1], obs_seg[0], P2, P3, P3); end
      n_cmp++; if (obs_order_err !== 0) begin n_fail++; $display("FAIL order_233: got %0d order errors want 0", obs_order_err); end
   endtask

   task automatic test_lz;
      int low;
      send(0, 8'd7, low);
      observe(0);
      n_cmp++; if ({obs_seg[2], obs_seg[1], obs_seg[0]} !== {OFF, OFF, P7}) begin n_fail++; $display("FAIL lz_on_7: got %b %b %b want %b %b %b", obs_seg[2], obs_seg[1], obs_seg[0], OFF, OFF, P7); end
      send(1, 8'd7, low);
      observe(1);
      n_cmp++; if ({obs_seg[2], obs_seg[1], obs_seg[0]} !== {P0, P0, P7}) begin n_fail++; $display("FAIL lz_off_7: got %b %b %b want %b %b %b", obs_seg[2], obs_seg[1], obs_seg[0], P0, P0, P7); end
   endtask

   task automatic test_overflow;
      int low;
      send(2, 8'd255, low);
      n_cmp++; if (ovf_c !== 1'b1) begin n_fail++; $display("FAIL ovf_255: got %b want 1", ovf_c); end
      observe(2);
      n_cmp++; if ({obs_seg[1], obs_seg[0]} !== {DASH, DASH}) begin n_fail++; $display("FAIL dash_255: got %b %b want %b %b", obs_seg[1], obs_seg[0], DASH, DASH); end
      send(2, 8'd42, low);
      n_cmp++; if (ovf_c !== 1'b0) begin n_fail++; $display("FAIL ovf_42: got %b want 0", ovf_c); end
      observe(2);
      n_cmp++; if ({obs_seg[1], obs_seg[0]} !== {P4, P2}) begin n_fail++; $display("FAIL show_42: got %b %b want %b %b", obs_seg[1], obs_seg[0], P4, P2); end
   endtask

   task automatic test_scan_timing;
      observe(0);
      n_cmp++; if ({obs_act[2], obs_act[1], obs_act[0]} !== {32'd6, 32'd6, 32'd6}) begin n_fail++; $display("FAIL active_cycles: got %0d %0d %0d want 6 6 6", obs_act[2], obs_act[1], obs_act[0]); end
      n_cmp++; if (obs_blank !== 6) begin n_fail++; $display("FAIL blank_cycles: got %0d want 6", obs_blank); end
      n_cmp++; if (obs_blank_err !== 0) begin n_fail++; $display("FAIL blank_seg: got %0d lit blank cycles want 0", obs_blank_err); end
      n_cmp++; if (obs_bad !== 0) begin n_fail++; $display("FAIL one_low_enable: got %0d bad cycles want 0", obs_bad); end
      n_cmp++; if (obs_order_err !== 0) begin n_fail++; $display("FAIL scan_order: got %0d order errors want 0", obs_order_err); end
      observe(2);
      n_cmp++; if (obs_blank !== 4) begin n_fail++; $display("FAIL blank_cycles_c: got %0d want 4", obs_blank); end
   endtask

   task automatic test_ignore_busy;
      wait_ready(0);
      @(negedge clk);
      drive(0, 1'b1, 8'd50);
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      drive(0, 1'b1, 8'd99);
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h00);
      wait_ready(0);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (u_a.r_disp_bcd !== 12'h050) begin n_fail++; $display("FAIL ignore_busy: got %h want 050", u_a.r_disp_bcd); end
      n_cmp++; if (if_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL no_queue: got %b want 1", if_a.in_ready); end
   endtask

   task automatic test_reset_mid_conv;
      wait_ready(0);
      @(negedge clk);
      drive(0, 1'b1, 8'd123);
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++; if (if_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", if_a.in_ready); end
      n_cmp++; if (u_a.r_disp_bcd !== 12'h000) begin n_fail++; $display("FAIL midreset_disp: got %h want 000", u_a.r_disp_bcd); end
      n_cmp++; if ({seg_a, en_a} !== {OFF, 3'b111}) begin n_fail++; $display("FAIL midreset_out: got %b %b want %b 111", seg_a, en_a, OFF); end
      repeat (12) @(posedge clk);
      #1;
      n_cmp++; if (u_a.r_disp_bcd !== 12'h000) begin n_fail++; $display("FAIL midreset_abort: got %h want 000", u_a.r_disp_bcd); end
   endtask

   initial begin
      test_reset;
      test_zero;
      test_value_233;
      test_lz;
      test_overflow;
      test_scan_timing;
      test_ignore_busy;
      test_reset_mid_conv;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
